// File: rtl/dense_layer_seq.sv
// Time-multiplexed fully-connected layer: one signed MAC per cycle over run-time loaded weights,
// followed by ReLU or linear saturation into per-neuron output slots.
module dense_layer_seq #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 8,
  parameter int unsigned X_W   = 4,
  parameter int unsigned W_W   = 8,
  parameter int unsigned ACC_W = 16,
  parameter int unsigned OUT_W = 10,
  parameter int unsigned RELU  = 1,
  localparam int unsigned AW   = ($clog2(N_IN * N_OUT) > 0) ? $clog2(N_IN * N_OUT) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     wr_en_i,
  input  logic [AW-1:0]            wr_addr_i,
  input  logic signed [W_W-1:0]    wr_data_i,
  input  logic                     start_i,
  input  logic [N_IN*X_W-1:0]      x_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [N_OUT*OUT_W-1:0]   y_o
);

  localparam int unsigned NW  = N_IN * N_OUT;
  localparam int unsigned IW  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned JW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int unsigned P_W = X_W + W_W + 1;

  localparam logic signed [ACC_W-1:0] UMAX = ACC_W'((64'sd1 <<< OUT_W) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-(64'sd1 <<< (OUT_W - 1)));

  typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

  state_e                   state_q, state_d;
  logic [N_IN*X_W-1:0]      x_q;
  logic [IW-1:0]            i_q;
  logic [JW-1:0]            j_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [W_W-1:0]    w_q [NW];
  logic [N_OUT*OUT_W-1:0]   y_q;

  logic                     start_ok, last_i, last_j, wr_ok;
  logic [AW-1:0]            w_idx;
  logic [X_W-1:0]           x_cur;
  logic signed [W_W-1:0]    w_cur;
  logic signed [P_W-1:0]    x_ext, w_ext, prod;
  logic signed [ACC_W-1:0]  sum;
  logic [OUT_W-1:0]         y_new;

  // DONE behaves like IDLE for accepting a new pass, so only MAC blocks starts and writes.
  assign start_ok = en_i & start_i & (state_q != StMac);
  assign wr_ok    = en_i & wr_en_i & (state_q != StMac) & (32'(wr_addr_i) < NW);
  assign last_i   = (i_q == IW'(N_IN - 1));
  assign last_j   = (j_q == JW'(N_OUT - 1));

  assign w_idx = AW'(32'(j_q) * N_IN + 32'(i_q));
  assign x_cur = x_q[i_q*X_W +: X_W];
  assign w_cur = w_q[w_idx];
  assign x_ext = P_W'($signed({1'b0, x_cur}));
  assign w_ext = P_W'(w_cur);
  assign prod  = x_ext * w_ext;
  assign sum   = acc_q + ACC_W'(prod);

  always_comb begin
    y_new = '0;
    if (RELU != 0) begin
      if (sum < 0)          y_new = '0;
      else if (sum > UMAX)  y_new = UMAX[OUT_W-1:0];
      else                  y_new = sum[OUT_W-1:0];
    end else begin
      if (sum < SMIN)       y_new = SMIN[OUT_W-1:0];
      else if (sum > SMAX)  y_new = SMAX[OUT_W-1:0];
      else                  y_new = sum[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (en_i) begin
      unique case (state_q)
        StIdle:  if (start_i) state_d = StMac;
        StMac:   if (last_i && last_j) state_d = StDone;
        StDone:  state_d = start_i ? StMac : StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    busy_o = (state_q == StMac);
    done_o = (state_q == StDone);
  end

  assign y_o = y_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q   <= '0;
      i_q   <= '0;
      j_q   <= '0;
      acc_q <= '0;
      y_q   <= '0;
      for (int k = 0; k < int'(NW); k++) w_q[k] <= '0;
    end else if (en_i) begin
      if (wr_ok) w_q[wr_addr_i] <= wr_data_i;
      if (start_ok) begin
        x_q   <= x_i;
        i_q   <= '0;
        j_q   <= '0;
        acc_q <= '0;
      end else if (state_q == StMac) begin
        if (last_i) begin
          y_q[j_q*OUT_W +: OUT_W] <= y_new;
          acc_q <= '0;
          i_q   <= '0;
          j_q   <= last_j ? '0 : j_q + JW'(1);
        end else begin
          acc_q <= sum;
          i_q   <= i_q + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Directed bench for dense_layer_seq at default sizes; a ReLU and a linear instance share stimulus.
module tb_dense_layer_seq;

  logic               clk = 1'b0;
  logic               rst_i, en_i, wr_en_i, start_i;
  logic [4:0]         wr_addr_i;
  logic signed [7:0]  wr_data_i;
  logic [15:0]        x_i;
  logic               busy_o, done_o, busy_lin, done_lin;
  logic [79:0]        y_o, y_lin;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dense_layer_seq #(.RELU(1)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .start_i(start_i), .x_i(x_i), .busy_o(busy_o), .done_o(done_o),
    .y_o(y_o)
  );

  dense_layer_seq #(.RELU(0)) dut_lin (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .start_i(start_i), .x_i(x_i), .busy_o(busy_lin), .done_o(done_lin),
    .y_o(y_lin)
  );

  function automatic logic [9:0] y_of(input logic [79:0] v, input int j);
    return v[j*10 +: 10];
  endfunction

  task automatic write_w(input int a, input logic signed [7:0] d);
    wr_en_i = 1'b1; wr_addr_i = 5'(a); wr_data_i = d;
    @(posedge clk); #1;
    wr_en_i = 1'b0;
  endtask

  task automatic load_all(input logic signed [7:0] d);
    for (int k = 0; k < 32; k++) write_w(k, d);
  endtask

  // Drives one pass from cycle 0 (start accepted) and reports observations only.
  task automatic run_pass(input int ign_at, input int wr_at, input int stall_at,
                          input int stall_len, output int done_at, output int busy_cnt);
    done_at = -1; busy_cnt = 0;
    for (int cyc = 0; cyc < 80 && done_at < 0; cyc++) begin
      start_i   = (cyc == 0) || (cyc == ign_at);
      en_i      = !(cyc >= stall_at && cyc < stall_at + stall_len);
      wr_en_i   = (cyc == wr_at);
      wr_addr_i = 5'd0;
      wr_data_i = 8'sd5;
      @(negedge clk);
      if (busy_o) busy_cnt++;
      if (done_o) done_at = cyc;
      @(posedge clk); #1;
    end
    start_i = 1'b0; en_i = 1'b1; wr_en_i = 1'b0;
  endtask

  task automatic test_reset;
    int d, b;
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({busy_o, done_o} !== 2'b00) begin
      n_bad++; $display("FAIL reset_ctl got %b want 00", {busy_o, done_o});
    end
    n_vec++;
    if (y_o !== 80'd0 || y_lin !== 80'd0) begin
      n_bad++; $display("FAIL reset_y got %h/%h want 0", y_o, y_lin);
    end
    @(posedge clk); #1;
    x_i = 16'h4321;
    run_pass(-1, -1, -1, 0, d, b);
    n_vec++;
    if (d !== 33) begin n_bad++; $display("FAIL reset_pass_done got %0d want 33", d); end
    n_vec++;
    if (y_o !== 80'd0 || y_lin !== 80'd0) begin
      n_bad++; $display("FAIL reset_pass_y got %h/%h want 0", y_o, y_lin);
    end
  endtask

  task automatic test_basic;
    int d, b;
    load_all(8'sd1);
    x_i = 16'h4321;
    run_pass(-1, -1, -1, 0, d, b);
    n_vec++;
    if (d !== 33) begin n_bad++; $display("FAIL basic_done got %0d want 33", d); end
    n_vec++;
    if (b !== 32) begin n_bad++; $display("FAIL basic_busy got %0d want 32", b); end
    for (int j = 0; j < 8; j++) begin
      n_vec++;
      if (y_of(y_o, j) !== 10'd10 || y_of(y_lin, j) !== 10'd10) begin
        n_bad++;
        $display("FAIL basic_y%0d got %0d/%0d want 10", j, y_of(y_o, j), y_of(y_lin, j));
      end
    end
  endtask

  task automatic check_sign_sat(input string tag);
    logic [9:0] er [8];
    logic [9:0] el [8];
    er[0] = 10'd0;    el[0] = 10'h220;  // -480
    er[1] = 10'd1023; el[1] = 10'd511;
    for (int j = 2; j < 8; j++) begin er[j] = 10'd60; el[j] = 10'd60; end
    for (int j = 0; j < 8; j++) begin
      n_vec++;
      if (y_of(y_o, j) !== er[j] || y_of(y_lin, j) !== el[j]) begin
        n_bad++;
        $display("FAIL %s_y%0d got %h/%h want %h/%h", tag, j, y_of(y_o, j), y_of(y_lin, j),
                 er[j], el[j]);
      end
    end
  endtask

  task automatic test_sign_sat;
    int d, b;
    for (int k = 0; k < 4; k++) write_w(k, -8'sd8);
    for (int k = 4; k < 8; k++) write_w(k, 8'sd127);
    x_i = 16'hFFFF;
    run_pass(-1, -1, -1, 0, d, b);
    n_vec++;
    if (d !== 33) begin n_bad++; $display("FAIL sat_done got %0d want 33", d); end
    check_sign_sat("sat");
  endtask

  task automatic test_protocol;
    int d, b;
    run_pass(10, 12, -1, 0, d, b);
    n_vec++;
    if (d !== 33 || b !== 32) begin
      n_bad++; $display("FAIL proto_timing got done=%0d busy=%0d want 33/32", d, b);
    end
    check_sign_sat("proto1");
    run_pass(-1, -1, -1, 0, d, b);
    n_vec++;
    if (d !== 33) begin n_bad++; $display("FAIL proto2_done got %0d want 33", d); end
    check_sign_sat("proto2");
  endtask

  task automatic test_reset_mid_pass;
    int d, b;
    for (int cyc = 0; cyc < 12; cyc++) begin
      start_i = (cyc == 0);
      rst_i   = (cyc == 10);
      @(negedge clk);
      if (cyc == 11) begin
        n_vec++;
        if ({busy_o, done_o} !== 2'b00 || y_o !== 80'd0 || y_lin !== 80'd0) begin
          n_bad++;
          $display("FAIL midrst got busy=%b done=%b y=%h/%h want 0", busy_o, done_o, y_o, y_lin);
        end
      end
      @(posedge clk); #1;
    end
    start_i = 1'b0; rst_i = 1'b0;
    x_i = 16'hFFFF;
    run_pass(-1, -1, -1, 0, d, b);
    n_vec++;
    if (d !== 33 || y_o !== 80'd0 || y_lin !== 80'd0) begin
      n_bad++; $display("FAIL midrst_pass got done=%0d y=%h/%h want 33/0", d, y_o, y_lin);
    end
  endtask

  task automatic test_stall;
    int d, b;
    load_all(8'sd1);
    x_i = 16'h4321;
    run_pass(-1, -1, 8, 5, d, b);
    n_vec++;
    if (d !== 38) begin n_bad++; $display("FAIL stall_done got %0d want 38", d); end
    n_vec++;
    if (b !== 37) begin n_bad++; $display("FAIL stall_busy got %0d want 37", b); end
    for (int j = 0; j < 8; j++) begin
      n_vec++;
      if (y_of(y_o, j) !== 10'd10) begin
        n_bad++; $display("FAIL stall_y%0d got %0d want 10", j, y_of(y_o, j));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic eb, ed;
    logic [9:0] ey;
    x_i = 16'h4321;
    for (int cyc = 0; cyc < 69; cyc++) begin
      start_i = (cyc <= 33);
      if (cyc == 5) x_i = 16'hFFFF;  // second pass should pick this up at its own start
      eb = (cyc >= 1 && cyc <= 32) || (cyc >= 34 && cyc <= 65);
      ed = (cyc == 33) || (cyc == 66);
      @(negedge clk);
      n_vec++;
      if ({busy_o, done_o} !== {eb, ed}) begin
        n_bad++; $display("FAIL b2b_ctl cyc %0d got %b want %b", cyc, {busy_o, done_o}, {eb, ed});
      end
      if (ed) begin
        ey = (cyc == 33) ? 10'd10 : 10'd60;
        for (int j = 0; j < 8; j++) begin
          n_vec++;
          if (y_of(y_o, j) !== ey) begin
            n_bad++;
            $display("FAIL b2b_y%0d cyc %0d got %0d want %0d", j, cyc, y_of(y_o, j), ey);
          end
        end
      end
      @(posedge clk); #1;
    end
    start_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b1; wr_en_i = 1'b0; start_i = 1'b0;
    wr_addr_i = '0; wr_data_i = '0; x_i = '0;
    test_reset;
    test_basic;
    test_sign_sat;
    test_protocol;
    test_reset_mid_pass;
    test_stall;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
